// File: rtl/instr_pkg.sv
// Shared encoding constants and helpers for instr_encoder.
// Covers format codes, opcodes, the NOP word and the FIFO geometry.
package instr_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_LW  = 3'd2,
    FMT_SW  = 3'd3,
    FMT_BEQ = 3'd4
  } fmt_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_WIDTH = 32;

  // Only the low 12 immediate bits reach the encoding; wider values truncate.
  function automatic logic [31:0] encode(input logic [2:0]  fmt,
                                         input logic [4:0]  rd,
                                         input logic [4:0]  rs1,
                                         input logic [4:0]  rs2,
                                         input logic [2:0]  funct3,
                                         input logic [6:0]  funct7,
                                         input logic [11:0] imm);
    logic [31:0] word;
    word = NOP_WORD;
    case (fmt)
      FMT_R:   word = {funct7, rs2, rs1, funct3, rd, OPC_OP};
      FMT_I:   word = {imm[11:0], rs1, funct3, rd, OPC_OP_IMM};
      FMT_LW:  word = {imm[11:0], rs1, F3_WORD, rd, OPC_LOAD};
      FMT_SW:  word = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OPC_STORE};
      // imm is a halfword offset, so imm[0] lands in the B-type bit 8 slot
      FMT_BEQ: word = {imm[11], imm[9:4], rs2, rs1, F3_BEQ, imm[3:0], imm[10], OPC_BRANCH};
      default: word = NOP_WORD;
    endcase
    return word;
  endfunction

  // hi is imm[31:11]; a 12-bit signed immediate needs all of it equal.
  function automatic logic imm_ok(input logic [2:0] fmt, input logic [20:0] hi);
    logic ok;
    ok = 1'b0;
    case (fmt)
      FMT_R:                       ok = 1'b1;
      FMT_I, FMT_LW, FMT_SW, FMT_BEQ: ok = (hi == '0) || (hi == '1);
      default:                     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Small synchronous FIFO holding encoded words; head is read combinationally.
// Output data reads as zero whenever the FIFO is empty.
module enc_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && (count != CW'(DEPTH)) && !flush_i;
  assign do_pop  = pop_i && (count != '0) && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: empty is signalled by count, and rdata is gated.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

  assign rdata_o = (count == '0) ? '0 : mem[rd_ptr];
  assign count_o = count;

endmodule

// File: rtl/instr_encoder.sv
// Encodes R/I/LW/SW/BEQ requests into 32-bit words queued in a 4-deep FIFO.
// Optional IMM_RANGE_CHECK_EN adds a sticky immediate-range / illegal-format error.
module instr_encoder
  import instr_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  fmt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] addr_o,
  output logic [2:0]  count_o,
  output logic        err_o
);

  logic [2:0]  count;
  logic [31:0] enc_word;
  logic [31:0] addr_q;
  logic        push;
  logic        pop;

  // Readiness depends on occupancy only, so a pop never frees a slot in the same cycle.
  assign req_ready_o   = (count < 3'(FIFO_DEPTH));
  assign instr_valid_o = (count != '0);
  assign push          = req_valid_i && req_ready_o && !flush_i;
  assign pop           = instr_valid_o && instr_ready_i && !flush_i;

  assign enc_word = encode(fmt_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i[11:0]);

  enc_fifo #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .wdata_i (enc_word),
    .pop_i   (pop),
    .rdata_o (instr_o),
    .count_o (count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
    end else if (flush_i) begin
      addr_q <= '0;
    end else if (pop) begin
      addr_q <= addr_q + 32'd4;
    end
  end

  assign addr_o  = addr_q;
  assign count_o = count;

`ifdef IMM_RANGE_CHECK_EN
  logic err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (flush_i) begin
      err_q <= 1'b0;
    end else if (push && !imm_ok(fmt_i, imm_i[31:11])) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_imm_hi;

  assign unused_imm_hi = ^imm_i[31:12];
  assign err_o         = 1'b0;
`endif

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have these ports: clk_i  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: rst_i  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: flush_i  in  1  synchronous clear of FIFO, address counter and error flag.
REQ-004 SHALL have: req_valid_i  in  1  request present; req_ready_o  out  1  request can be accepted.
REQ-005 SHALL have: fmt_i  in  3  format code (0 R, 1 I-ALU, 2 LW, 3 SW, 4 BEQ, 5-7 illegal).
REQ-006 SHALL have: rd_i, rs1_i, rs2_i  in  5 each; funct3_i  in  3; funct7_i  in  7; imm_i  in  32  immediate, sign-extended form.
REQ-007 SHALL have: instr_valid_o  out  1; instr_ready_i  in  1; instr_o  out  32  encoded word at FIFO head.
REQ-008 SHALL have: addr_o  out  32  byte address of head word; count_o  out  3  FIFO occupancy 0-4; err_o  out  1  sticky range error.

Function
REQ-009 SHALL accept a request on a rising edge with req_valid_i and req_ready_o both high.
REQ-010 SHALL encode R as {funct7, rs2, rs1, funct3, rd, 0110011}.
REQ-011 SHALL encode I-ALU as {imm[11:0], rs1, funct3, rd, 0010011}; LW as {imm[11:0], rs1, 010, rd, 0000011}.
REQ-012 SHALL encode SW as {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}; funct3_i ignored for LW/SW.
REQ-013 SHALL encode BEQ with imm as halfword offset: bit31=imm[11], bit7=imm[10], bits30:25=imm[9:4], bits11:8=imm[3:0], funct3 000, opcode 1100011.
REQ-014 SHALL make decoding of any in-range encoded word reproduce imm_i exactly.
REQ-015 SHALL encode illegal fmt as NOP 0x00000013.
REQ-016 SHALL write each accepted word into a 4-entry FIFO; instr_valid_o high the cycle after acceptance (latency 1, no bypass).
REQ-017 SHALL drive req_ready_o = (count_o < 4); when full, req_ready_o stays low even if a pop occurs that cycle.
REQ-018 SHALL pop on instr_valid_o && instr_ready_i; simultaneous push and pop leave count_o unchanged.
REQ-019 SHALL hold instr_o and addr_o stable while instr_valid_o high and instr_ready_i low.
REQ-020 SHALL increment addr_o by 4 per pop, wrapping 0xFFFFFFFC to 0.
REQ-021 SHALL give flush_i priority over push and pop: count_o=0, addr_o=0, err_o=0 next cycle, request that cycle dropped.

Reset
REQ-022 SHALL on rst_i immediately force count_o=0, instr_valid_o=0, addr_o=0, err_o=0, req_ready_o=1; instr_o=0.
REQ-023 SHALL discard FIFO contents on reset asserted mid-transfer; first word after release gets addr_o=0.

Configuration
REQ-024 SHALL, with IMM_RANGE_CHECK_EN defined, set err_o on acceptance when imm_i[31:11] not all equal (fmt 1-4) or fmt illegal; sticky until flush/reset.
REQ-025 SHALL, without IMM_RANGE_CHECK_EN, tie err_o to 0 and omit the check logic; encoding unchanged (truncation).

Structure
REQ-026 SHALL place fmt codes, opcodes, NOP constant and FIFO depth in shared package instr_pkg.
REQ-027 SHALL implement the FIFO as sub-module enc_fifo (width 32, depth 4, count output).

Verification
REQ-028 R: fmt 0, rd 3, rs1 1, rs2 2, funct3 0, funct7 0 -> instr_o 0x002081B3, addr_o 0, one cycle after accept.
REQ-029 LW/SW: LW rd 5, rs1 2, imm 0xFFFFFFFC -> 0xFFC12283 at addr 0; SW rs2 6, rs1 2, imm 8 -> 0x00612423 at addr 4.
REQ-030 BEQ: rs1 1, rs2 2, imm 0xFFFFFFFE -> 0xFE208EE3; decoding returns 0xFFFFFFFE.
REQ-031 Backpressure: 5 back-to-back requests, instr_ready_i=0 -> 4 accepted, count_o 4, req_ready_o 0; release -> in-order drain, addr 0,4,8,12, then 5th accepted.
REQ-032 Range (macro on): I-ALU imm 0x800, rd/rs1/funct3 0 -> instr_o 0x80000013, err_o 1 held until flush_i; macro off -> err_o 0.
REQ-033 Reset/flush: assert rst_i with count 3 mid-pop -> outputs at reset values immediately; flush_i with simultaneous push -> count_o 0 next cycle.
